instr_fetch_unit: RTL and testbench

- Produces the instruction word and its PC for the decode/control stage. Consumes the taken-branch/jump redirect that decode/execute generate.
- Owns the PC register and talks to the instruction memory over a single-outstanding request/response port.
- Presents each instruction to decode with a valid/ready handshake.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/instr_fetch_unit_pc_reg.sv | 34 +++
 rtl/instr_fetch_unit.sv | 141 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, reset/NOP constants and base opcodes.
// S_HALT exists only when FETCH_ALIGN_CHECK_EN is defined.
package cpu_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0013;

  localparam logic [6:0] LUI   = 7'b0110111;
  localparam logic [6:0] AUIPC = 7'b0010111;
  localparam logic [6:0] JAL   = 7'b1101111;
  localparam logic [6:0] JALR  = 7'b1100111;
  localparam logic [6:0] BXX   = 7'b1100011;
  localparam logic [6:0] LXX   = 7'b0000011;
  localparam logic [6:0] SXX   = 7'b0100011;
  localparam logic [6:0] IXX   = 7'b0010011;
  localparam logic [6:0] RXX   = 7'b0110011;

`ifdef FETCH_ALIGN_CHECK_EN
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_VALID, S_HALT} fetch_state_e;
`else
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_VALID} fetch_state_e;
`endif

endpackage

// File: rtl/instr_fetch_unit_pc_reg.sv
// Program counter: reset load, redirect over sequential increment, 32-bit wrap.
// With FETCH_ALIGN_CHECK_EN defined it also flags misaligned redirect targets.
module pc_reg
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  input  logic        incr_en,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic        target_misaligned,
`endif
  output logic [31:0] pc
);

  // Adding 4 leaves pc[1:0] untouched, so a misaligned target stays misaligned.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (redirect_en) begin
      pc <= redirect_pc;
    end else if (incr_en) begin
      pc <= pc + 32'd4;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  assign target_misaligned = |redirect_pc[1:0];
`endif

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, single-outstanding imem request, valid/ready to decode.
// Define FETCH_ALIGN_CHECK_EN to halt with fetch_fault on a misaligned redirect target.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_fault
);

  fetch_state_e state, state_d;
  logic         stale, stale_d;
  logic         redir_en, incr_en, load_instr;
  logic [31:0]  pc;
  logic [31:0]  instr_q, instr_pc_q;
`ifdef FETCH_ALIGN_CHECK_EN
  logic         target_misaligned;
  logic         fault_q, fault_d;
`endif

  pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk         (clk),
    .reset       (reset),
    .redirect_en (redir_en),
    .redirect_pc (redirect_pc),
    .incr_en     (incr_en),
`ifdef FETCH_ALIGN_CHECK_EN
    .target_misaligned (target_misaligned),
`endif
    .pc          (pc)
  );

  // stale marks an outstanding request whose PC has been superseded by a redirect.
  always_comb begin
    state_d    = state;
    stale_d    = stale;
    redir_en   = 1'b0;
    incr_en    = 1'b0;
    load_instr = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    fault_d    = fault_q;
`endif
    case (state)
      S_REQ: begin
        state_d = S_WAIT;
        if (redirect_valid) begin
          redir_en = 1'b1;
          stale_d  = 1'b1;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          redir_en = 1'b1;
          if (imem_rvalid) begin
            state_d = S_REQ;
            stale_d = 1'b0;
          end else begin
            stale_d = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (stale) begin
            stale_d = 1'b0;
            state_d = S_REQ;
          end else begin
            load_instr = 1'b1;
            state_d    = S_VALID;
          end
        end
      end
      S_VALID: begin
        if (redirect_valid) begin
          redir_en = 1'b1;
          state_d  = S_REQ;
        end else if (instr_ready) begin
          incr_en = 1'b1;
          state_d = S_REQ;
        end
      end
      default: begin
        // S_HALT: only reset leaves it; responses and redirects are ignored.
      end
    endcase
`ifdef FETCH_ALIGN_CHECK_EN
    if (redir_en && target_misaligned) begin
      state_d = S_HALT;
      stale_d = 1'b0;
      fault_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_REQ;
      stale      <= 1'b0;
      instr_q    <= NOP_WORD;
      instr_pc_q <= RESET_PC;
    end else begin
      state <= state_d;
      stale <= stale_d;
      if (load_instr) begin
        instr_q    <= imem_rdata;
        instr_pc_q <= pc;
      end
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end
  assign fetch_fault = fault_q && !reset;
`else
  assign fetch_fault = 1'b0;
`endif

  // Outputs are gated by reset so they show reset values for the whole reset cycle.
  assign imem_req    = !reset && (state == S_REQ);
  assign imem_addr   = reset ? RESET_PC : pc;
  assign instr_valid = !reset && (state == S_VALID);
  assign instr       = instr_valid ? instr_q : NOP_WORD;
  assign instr_pc    = reset ? RESET_PC : instr_pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a latency-programmable memory model and
// request/instruction scoreboards. Define FETCH_ALIGN_CHECK_EN to cover the halt path.
module tb_instr_fetch_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        fetch_fault;

  int compared = 0;
  int mismatched = 0;

  logic [31:0] exp_addr[$];
  logic [31:0] exp_ipc[$];
  logic [31:0] exp_iw[$];

  int          mem_lat = 1;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = 32'h0;

  instr_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_fault    (fetch_fault)
  );

  always #5 clk = ~clk;

  // ADDI x1,x0,imm with imm derived from the address; address 0 gives 32'h00500093.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [11:0] imm;
    imm = a[13:2] + 12'd5;
    return {imm, 5'd0, 3'b000, 5'd1, IXX};
  endfunction

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic exp_req(input logic [31:0] a);
    exp_addr.push_back(a);
  endtask

  task automatic exp_fetch(input logic [31:0] a);
    exp_ipc.push_back(a);
    exp_iw.push_back(mem_word(a));
  endtask

  task automatic observe();
    #1;
    if (!reset) begin
      if (imem_req) begin
        if (exp_addr.size() == 0) chk32("req_unexpected", 32'(exp_addr.size()), 32'd1);
        else chk32("req_addr", imem_addr, exp_addr.pop_front());
        mem_addr = imem_addr;
        mem_cnt  = mem_lat;
      end
      if (instr_valid && instr_ready && !redirect_valid) begin
        if (exp_ipc.size() == 0) chk32("hs_unexpected", 32'(exp_ipc.size()), 32'd1);
        else begin
          chk32("instr_pc", instr_pc, exp_ipc.pop_front());
          chk32("instr", instr, exp_iw.pop_front());
        end
      end
      if (!instr_valid) chk32("nop_when_idle", instr, NOP_WORD_DEFAULT);
    end
  endtask

  task automatic tick();
    observe();
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    if (reset) mem_cnt = 0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    if (mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(mem_addr);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    #1;
    chkb({tag, "_req"}, imem_req, 1'b0);
    chk32({tag, "_addr"}, imem_addr, RESET_PC_DEFAULT);
    chkb({tag, "_valid"}, instr_valid, 1'b0);
    chk32({tag, "_instr"}, instr, NOP_WORD_DEFAULT);
    chk32({tag, "_pc"}, instr_pc, RESET_PC_DEFAULT);
    chkb({tag, "_fault"}, fetch_fault, 1'b0);
  endtask

  initial begin
    // Reset with a redirect and a stray response that must not be honoured.
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    imem_rvalid    = 1'b1;
    imem_rdata     = 32'hDEAD_BEEF;
    tick();
    check_reset_outputs("rst");

    // Sequential fetch, zero-wait memory, decode always ready.
    exp_req(32'h0); exp_req(32'h4); exp_req(32'h8);
    exp_fetch(32'h0); exp_fetch(32'h4); exp_fetch(32'h8);
    reset = 1'b0;
    instr_ready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      #1;
      chkb("t1_req", imem_req, (c % 3) == 0);
      chkb("t1_valid", instr_valid, (c % 3) == 2);
      tick();
    end

    // Decode stalls for 5 cycles.
    exp_req(32'hC); exp_fetch(32'hC);
    instr_ready = 1'b0;
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      chkb("t2_hold_valid", instr_valid, 1'b1);
      chk32("t2_hold_instr", instr, mem_word(32'hC));
      chk32("t2_hold_pc", instr_pc, 32'hC);
      chkb("t2_hold_noreq", imem_req, 1'b0);
      tick();
    end
    instr_ready = 1'b1;
    exp_req(32'h10);
    #1 chkb("t2_ready_noreq", imem_req, 1'b0);
    tick();
    #1 chkb("t2_req_after", imem_req, 1'b1);
    chk32("t2_addr_after", imem_addr, 32'h10);

    // Redirect during S_WAIT; the old response comes 3 cycles after its request.
    mem_lat = 3;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    exp_req(32'h100); exp_fetch(32'h100);
    mem_lat = 1;
    tick();
    #1 chkb("t3_wait_valid", instr_valid, 1'b0);
    tick();
    #1 chkb("t3_stale_valid", instr_valid, 1'b0);
    tick();
    #1 chkb("t3_rereq", imem_req, 1'b1);
    chk32("t3_rereq_addr", imem_addr, 32'h100);
    tick(); tick();
    #1 chkb("t3_valid", instr_valid, 1'b1);
    chk32("t3_pc", instr_pc, 32'h100);

    // Redirect in S_VALID with instr_ready high: held instruction dropped.
    exp_req(32'h104);
    tick(); tick(); tick();
    #1 chkb("t4_valid", instr_valid, 1'b1);
    chk32("t4_pc", instr_pc, 32'h104);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    exp_req(32'h40);
    tick();
    #1 chkb("t4_req", imem_req, 1'b1);
    chk32("t4_addr", imem_addr, 32'h40);
    chkb("t4_dropped", instr_valid, 1'b0);

    // Redirect coinciding with the response: data discarded, re-request.
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    exp_req(32'h40); exp_fetch(32'h40);
    tick();
    #1 chkb("t5_req", imem_req, 1'b1);
    chkb("t5_no_valid", instr_valid, 1'b0);
    tick(); tick();
    #1 chkb("t5_valid", instr_valid, 1'b1);
    chk32("t5_pc", instr_pc, 32'h40);

    // PC wrap from 0xFFFF_FFFC to 0.
    exp_req(32'h44);
    tick(); tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    exp_req(32'hFFFF_FFFC); exp_fetch(32'hFFFF_FFFC); exp_req(32'h0);
    tick(); tick(); tick();
    #1 chk32("wrap_pc", instr_pc, 32'hFFFF_FFFC);
    tick();
    #1 chkb("wrap_req", imem_req, 1'b1);
    chk32("wrap_addr", imem_addr, 32'h0);

    // Reset in S_WAIT while the response arrives, then a stray response after it.
    tick();
    reset = 1'b1;
    check_reset_outputs("rst_wait");
    tick();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    check_reset_outputs("rst_hold");
    exp_req(32'h0); exp_fetch(32'h0); exp_req(32'h4);
    reset = 1'b0;
    #1 chkb("rst_first_req", imem_req, 1'b1);
    tick(); tick();
    #1 chk32("rst_first_pc", instr_pc, 32'h0);
    tick();

    // Misaligned redirect target.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
`ifdef FETCH_ALIGN_CHECK_EN
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      chkb("halt_fault", fetch_fault, 1'b1);
      chkb("halt_noreq", imem_req, 1'b0);
      chkb("halt_novalid", instr_valid, 1'b0);
      tick();
    end
    reset = 1'b1;
    #1 chkb("halt_rst_fault", fetch_fault, 1'b0);
    exp_req(32'h0);
    tick();
    reset = 1'b0;
    #1 chkb("halt_exit_req", imem_req, 1'b1);
    tick();
`else
    exp_req(32'h102); exp_fetch(32'h102); exp_req(32'h106);
    tick();
    #1 chkb("mis_fault", fetch_fault, 1'b0);
    tick();
    #1 chkb("mis_req", imem_req, 1'b1);
    chk32("mis_addr", imem_addr, 32'h102);
    tick(); tick();
    #1 chkb("mis_valid", instr_valid, 1'b1);
    chk32("mis_pc", instr_pc, 32'h102);
    tick(); tick();
`endif

    chk32("sb_addr_left", 32'(exp_addr.size()), 32'd0);
    chk32("sb_instr_left", 32'(exp_ipc.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
